// File: rtl/tone_synth_pkg.sv
// rtl/tone_synth_pkg.sv - shared state enum, table geometry, envelope defaults and lookup helpers
package tone_synth_pkg;

  localparam int SINE_DEPTH       = 256;
  localparam int SINE_AW          = 8;
  localparam int SINE_W           = 15;
  localparam int ENV_MAX          = 255;
  localparam int DEF_ATTACK_STEP  = 8;
  localparam int DEF_RELEASE_STEP = 4;
  localparam bit DEF_RETRIGGER    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_ROM  = 3'd2,
    ST_ROM2 = 3'd3,
    ST_MUL  = 3'd4,
    ST_OUT  = 3'd5
  } state_t;

  // Entry i = round(32767 * sin(pi/2 * (i + 0.5) / 256)); the half-step offset keeps the quadrant mirror exact.
  function automatic logic [SINE_W-1:0] sine_entry(input int i);
    real angle;
    angle = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(SINE_DEPTH);
    return SINE_W'($rtoi(32767.0 * $sin(angle) + 0.5));
  endfunction

  // Phase bits [15:6] in, {negate, quarter-wave address} out.
  function automatic logic [SINE_AW:0] sine_lookup_addr(input logic [9:0] p);
    return {p[9], (p[8] ? ~p[7:0] : p[7:0])};
  endfunction

  function automatic logic signed [15:0] apply_sign(input logic neg, input logic [SINE_W-1:0] mag);
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// rtl/tone_synth_if.sv - note/mute inputs and per-sample codec handshake of the tone synthesiser
interface tone_synth_if;

  logic [15:0] i_phase_inc;
  logic        i_mute;
  logic        i_sample_req;
  logic [15:0] o_sample_out;
  logic        o_sample_valid;
  logic        o_busy;
  logic        o_overrun;

  modport master (
    output i_phase_inc, i_mute, i_sample_req,
    input  o_sample_out, o_sample_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_phase_inc, i_mute, i_sample_req,
    output o_sample_out, o_sample_valid, o_busy, o_overrun
  );

endinterface

// File: rtl/tone_synth_sine_rom_q.sv
// rtl/tone_synth_sine_rom_q.sv - quarter-wave sine table, 256 x 15 bit, one-cycle registered read
module sine_rom_q
  import tone_synth_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [SINE_AW-1:0] i_addr,
  output logic [SINE_W-1:0]  o_data
);

  logic [SINE_W-1:0] w_table [SINE_DEPTH];
  logic [SINE_W-1:0] r_data;

  for (genvar g = 0; g < SINE_DEPTH; g++) begin : g_entry
    assign w_table[g] = sine_entry(g);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_table[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/tone_synth.sv
// rtl/tone_synth.sv - note word to enveloped 16-bit PCM sine, one sample per codec request
// Build option TONE_SYNTH_HARMONIC_EN mixes in a second harmonic via an extra ROM cycle.
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP,
  parameter bit RETRIGGER    = DEF_RETRIGGER
) (
  input logic         clk,
  input logic         rst_n,
  tone_synth_if.slave io_bus
);

  state_t r_state;
  state_t w_state_next;

  logic [15:0] r_acc;
  logic [15:0] r_cur_inc;
  logic [15:0] r_last_inc;
  logic [7:0]  r_env;
  logic [9:0]  r_phase;
  logic signed [15:0] r_sample_pre;
  logic [15:0] r_sample_out;
  logic        r_valid;
  logic        r_busy;
  logic        r_overrun;

  logic              w_rom_en;
  logic [SINE_AW-1:0] w_rom_addr;
  logic [SINE_W-1:0]  w_rom_data;
  logic [SINE_AW:0]   w_lk1;
  logic [8:0]         w_env_up;
  logic [8:0]         w_env_dn;
  logic [7:0]         w_env_next;
  logic               w_neg;
  logic [SINE_W-1:0]  w_mag_in;
  logic [22:0]        w_prod;
  logic [SINE_W-1:0]  w_mag;
  logic signed [15:0] w_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rom_en     = 1'b0;
    case (r_state)
      ST_IDLE: if (io_bus.i_sample_req) w_state_next = ST_ACC;
      ST_ACC:  w_state_next = ST_ROM;
      ST_ROM: begin
        w_rom_en = 1'b1;
`ifdef TONE_SYNTH_HARMONIC_EN
        w_state_next = ST_ROM2;
`else
        w_state_next = ST_MUL;
`endif
      end
      ST_ROM2: begin
        w_rom_en     = 1'b1;
        w_state_next = ST_MUL;
      end
      ST_MUL:  w_state_next = ST_OUT;
      ST_OUT:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // 9-bit envelope arithmetic: bit 8 flags overflow on attack and borrow on release.
  assign w_env_up = {1'b0, r_env} + 9'(ATTACK_STEP);
  assign w_env_dn = {1'b0, r_env} - 9'(RELEASE_STEP);

  always_comb begin
    w_env_next = r_env;
    if ((r_cur_inc != '0) && !io_bus.i_mute) begin
      if (RETRIGGER && (r_cur_inc != r_last_inc)) begin
        w_env_next = 8'(ATTACK_STEP);
      end else if (w_env_up > 9'(ENV_MAX)) begin
        w_env_next = 8'(ENV_MAX);
      end else begin
        w_env_next = w_env_up[7:0];
      end
    end else if (w_env_dn[8]) begin
      w_env_next = '0;
    end else begin
      w_env_next = w_env_dn[7:0];
    end
  end

  assign w_lk1 = sine_lookup_addr(r_phase);

`ifdef TONE_SYNTH_HARMONIC_EN
  logic [9:0]         r_phase2;
  logic signed [15:0] r_s1;
  logic [SINE_AW:0]   w_lk2;
  logic signed [15:0] w_s2;
  logic signed [16:0] w_s1x;
  logic signed [16:0] w_s2x;
  logic signed [16:0] w_mix;
  logic signed [16:0] w_abs;

  // One ROM serves both lookups: fundamental in ROM, harmonic (phase doubled) in ROM2.
  assign w_lk2      = sine_lookup_addr(r_phase2);
  assign w_rom_addr = (r_state == ST_ROM2) ? w_lk2[SINE_AW-1:0] : w_lk1[SINE_AW-1:0];
  assign w_s2       = apply_sign(w_lk2[SINE_AW], w_rom_data);
  assign w_s1x      = {r_s1[15], r_s1};
  assign w_s2x      = {w_s2[15], w_s2};
  assign w_mix      = w_s1x - (w_s1x >>> 2) + (w_s2x >>> 2);
  assign w_neg      = w_mix[16];
  assign w_abs      = w_neg ? -w_mix : w_mix;
  assign w_mag_in   = SINE_W'(w_abs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase2 <= '0;
      r_s1     <= '0;
    end else begin
      if (r_state == ST_ACC) r_phase2 <= r_acc[14:5];
      if (r_state == ST_ROM2) r_s1 <= apply_sign(w_lk1[SINE_AW], w_rom_data);
    end
  end
`else
  assign w_rom_addr = w_lk1[SINE_AW-1:0];
  assign w_neg      = w_lk1[SINE_AW];
  assign w_mag_in   = w_rom_data;
`endif

  assign w_prod   = 23'(w_mag_in) * 23'(r_env);
  assign w_mag    = SINE_W'(w_prod >> 8);
  assign w_sample = apply_sign(w_neg, w_mag);

  sine_rom_q u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_rom_en),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cur_inc    <= '0;
      r_last_inc   <= '0;
      r_env        <= '0;
      r_phase      <= '0;
      r_sample_pre <= '0;
      r_sample_out <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (io_bus.i_sample_req && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (io_bus.i_sample_req) begin
            r_cur_inc <= io_bus.i_phase_inc;
            r_busy    <= 1'b1;
          end
        end
        ST_ACC: begin
          r_phase    <= r_acc[15:6];
          r_env      <= w_env_next;
          r_last_inc <= r_cur_inc;
          // Silent and fully released: park the phase so the next note starts at zero crossing.
          if ((w_env_next == '0) && (r_cur_inc == '0)) begin
            r_acc <= '0;
          end else begin
            r_acc <= r_acc + r_cur_inc;
          end
        end
        ST_MUL: r_sample_pre <= w_sample;
        ST_OUT: begin
          r_sample_out <= r_sample_pre;
          r_valid      <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.o_sample_out   = r_sample_out;
  assign io_bus.o_sample_valid = r_valid;
  assign io_bus.o_busy         = r_busy;
  assign io_bus.o_overrun      = r_overrun;

endmodule
